// File: rtl/spn_host_ctrl_if.sv
// -----------------------------------------------------------------------------
// spn_host_ctrl_if
// Bundles the request port, response port, key-load port and the SPN core
// connection of spn_host_ctrl.
//   slave  : the host controller itself (drives req_ready, core_*, rsp_*)
//   master : the surrounding system (bus adapter, SPN core, response consumer)
// Signals:
//   key_wr/key_in                  key register load
//   req_valid/req_ready/req_op/
//   req_data                       request handshake
//   core_opcode/core_data_in/
//   core_key                       drive into the SPN core
//   core_data_out/core_valid       registered result from the SPN core
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_status                     response FIFO head handshake
// -----------------------------------------------------------------------------
interface spn_host_ctrl_if;
    logic        key_wr;
    logic [31:0] key_in;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data;

    logic [1:0]  core_opcode;
    logic [15:0] core_data_in;
    logic [31:0] core_key;
    logic [15:0] core_data_out;
    logic [1:0]  core_valid;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_status;

    modport slave (
        input  key_wr, key_in,
        input  req_valid, req_op, req_data,
        output req_ready,
        output core_opcode, core_data_in, core_key,
        input  core_data_out, core_valid,
        output rsp_valid, rsp_data, rsp_status,
        input  rsp_ready
    );

    modport master (
        output key_wr, key_in,
        output req_valid, req_op, req_data,
        input  req_ready,
        input  core_opcode, core_data_in, core_key,
        output core_data_out, core_valid,
        input  rsp_valid, rsp_data, rsp_status,
        output rsp_ready
    );
endinterface

// File: rtl/spn_host_ctrl.sv
// -----------------------------------------------------------------------------
// spn_host_ctrl
// Host-side initiator for the 3-round SPN core. Accepts one encrypt/decrypt
// request at a time, pulses it into the core for one cycle, waits for the
// core's registered result (or a timeout) and queues {data, status} in a
// small response FIFO.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : spn_host_ctrl_if.slave (request, key, core and response signals)
// Parameters:
//   RSP_DEPTH : response FIFO entries (power of two, >= 2)
//   TIMEOUT   : WAIT cycles with core_valid == 00 before a timeout response
// Status codes: 00 ok, 01 opcode mismatch, 10 timeout, 11 core illegal op.
// -----------------------------------------------------------------------------
module spn_host_ctrl #(
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 4
) (
    input logic            clk,
    input logic            rst,
    spn_host_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    // Response status for a result the core actually returned.
    function automatic logic [1:0] classify_status(input logic [1:0] valid,
                                                   input logic [1:0] op);
        logic [1:0] st;
        if (valid == 2'b11) begin
            st = 2'b11;
        end else if (valid == op) begin
            st = 2'b00;
        end else begin
            st = 2'b01;
        end
        return st;
    endfunction

    state_t             state_r, state_s;
    logic [1:0]         op_r;
    logic [15:0]        data_r;
    logic [1:0]         core_opcode_r, core_opcode_s;
    logic [31:0]        key_r;
    logic [TMO_W-1:0]   tmo_r, tmo_s;

    logic [17:0]        mem_r [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               req_ready_s;
    logic               accept_s;
    logic               latch_s;
    logic               push_s;
    logic               pop_s;
    logic [17:0]        push_word_s;

    // Ready only in IDLE with a free FIFO slot; forced low while in reset.
    assign req_ready_s = !rst && (state_r == ST_IDLE) &&
                         (count_r < CNT_W'(RSP_DEPTH));
    assign accept_s    = bus.req_valid && req_ready_s;
    assign pop_s       = bus.rsp_ready && (count_r != CNT_W'(0));

    assign bus.req_ready    = req_ready_s;
    assign bus.core_opcode  = core_opcode_r;
    assign bus.core_data_in = data_r;
    assign bus.core_key     = key_r;
    assign bus.rsp_valid    = (count_r != CNT_W'(0));
    assign bus.rsp_data     = mem_r[rd_ptr_r][17:2];
    assign bus.rsp_status   = mem_r[rd_ptr_r][1:0];

    // Next-state logic, timeout counting and response generation.
    always_comb begin
        state_s       = state_r;
        tmo_s         = tmo_r;
        latch_s       = 1'b0;
        push_s        = 1'b0;
        push_word_s   = 18'h0_0000;
        core_opcode_s = 2'b00;
        case (state_r)
            ST_IDLE: begin
                // A 00 request is consumed here without touching the core.
                if (accept_s && (bus.req_op != 2'b00)) begin
                    latch_s       = 1'b1;
                    core_opcode_s = bus.req_op;
                    state_s       = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                tmo_s   = TMO_W'(0);
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.core_valid != 2'b00) begin
                    push_s      = 1'b1;
                    push_word_s = {bus.core_data_out,
                                   classify_status(bus.core_valid, op_r)};
                    state_s     = ST_IDLE;
                end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th silent WAIT cycle.
                    push_s      = 1'b1;
                    push_word_s = {16'h0000, 2'b10};
                    state_s     = ST_IDLE;
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched request and registered core drive.
    // core_opcode is loaded at the accept edge so it is valid exactly
    // during the ISSUE cycle and cleared at the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            op_r          <= 2'b00;
            data_r        <= 16'h0000;
            core_opcode_r <= 2'b00;
            tmo_r         <= TMO_W'(0);
        end else begin
            state_r       <= state_s;
            core_opcode_r <= core_opcode_s;
            tmo_r         <= tmo_s;
            if (latch_s) begin
                op_r   <= bus.req_op;
                data_r <= bus.req_data;
            end
        end
    end

    // Key register; a write during ISSUE lands on the same edge the core
    // samples, so the core still sees the old key for that request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r <= 32'h0000_0000;
        end else if (bus.key_wr) begin
            key_r <= bus.key_in;
        end
    end

    // Response FIFO storage and pointers. The slot is reserved at accept
    // time, so a push never meets a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_r[i] <= 18'h0_0000;
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_W'(0);
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
